// File: rtl/if_id_fetch_queue_pkg.sv
// Shared constants and helpers for the IF/ID fetch queue.
// FETCHQ_BYPASS_EN (optional) enables the empty-queue push-to-pop bypass.
package if_id_fetch_queue_pkg;

  localparam int ADDRESS_LEN  = 32;
  localparam int FETCHQ_DEPTH = 4;

  function automatic bit depth_ok(input int n);
    return (n >= 2) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/if_id_fetch_queue_if.sv
// Fetch-to-decode handshake bundle: push side from fetch, pop side to decode.
// master = the fetch/decode environment, slave = the queue.
interface if_id_fetch_queue_if #(
  parameter int WIDTH = if_id_fetch_queue_pkg::ADDRESS_LEN
);
  logic             push_valid;
  logic [WIDTH-1:0] push_pc;
  logic [WIDTH-1:0] push_instr;
  logic             push_ready;
  logic             pop_valid;
  logic             pop_ready;
  logic [WIDTH-1:0] pop_pc;
  logic [WIDTH-1:0] pop_instr;

  modport master (
    output push_valid, push_pc, push_instr, pop_ready,
    input  push_ready, pop_valid, pop_pc, pop_instr
  );

  modport slave (
    input  push_valid, push_pc, push_instr, pop_ready,
    output push_ready, pop_valid, pop_pc, pop_instr
  );
endinterface

// File: rtl/if_id_fetch_queue_storage.sv
// Entry storage for the fetch queue: one write port, one asynchronous read port.
// Contents are never reset; validity is tracked by the queue's count.
module fetchq_storage #(
  parameter int DEPTH = 4,
  parameter int DW    = 64
) (
  input  logic                     clk,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [DW-1:0]            wr_data,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [DW-1:0]            rd_data
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/if_id_fetch_queue.sv
// IF/ID instruction queue: buffers {pc, instr} pairs from fetch, presents them in order to decode.
// Define FETCHQ_BYPASS_EN for a 0-cycle path from push to pop when the queue is empty.
module if_id_fetch_queue
  import if_id_fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEPTH,
  parameter int WIDTH = ADDRESS_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  if_id_fetch_queue_if.slave         fq,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  if (!depth_ok(DEPTH)) begin : g_depth_check
    $error("if_id_fetch_queue: DEPTH must be a power of 2 and >= 2");
  end

  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q,  count_d;
  logic [2*WIDTH-1:0] rd_data;
  logic               q_valid;
  logic               push_fire;
  logic               pop_fire;
  logic               bypass_hit;
  logic               bypass_take;
  logic               wr_en;

  fetchq_storage #(
    .DEPTH (DEPTH),
    .DW    (2 * WIDTH)
  ) u_storage (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (wr_ptr_q),
    .wr_data ({fq.push_pc, fq.push_instr}),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_data)
  );

  always_comb begin
    q_valid    = (count_q != '0);
    bypass_hit = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    bypass_hit = (count_q == '0) & fq.push_valid & ~flush;
`endif

    fq.push_ready = (count_q != FULL);
    fq.pop_valid  = q_valid | bypass_hit;
    if (bypass_hit) begin
      fq.pop_pc    = fq.push_pc;
      fq.pop_instr = fq.push_instr;
    end else if (q_valid) begin
      fq.pop_pc    = rd_data[2*WIDTH-1:WIDTH];
      fq.pop_instr = rd_data[WIDTH-1:0];
    end else begin
      fq.pop_pc    = '0;
      fq.pop_instr = '0;
    end

    push_fire   = fq.push_valid & fq.push_ready;
    pop_fire    = fq.pop_valid & fq.pop_ready;
    // A bypassed entry consumed in the same cycle never touches storage.
    bypass_take = bypass_hit & fq.pop_ready;
    wr_en       = push_fire & ~flush & ~bypass_take;

    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (!bypass_take) begin
      if (wr_en)    wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_fire) rd_ptr_d = rd_ptr_q + PW'(1);
      case ({wr_en, pop_fire})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count = count_q;

endmodule
